adder_sum_accumulator: RTL and testbench
========================================

ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the adder result data width.
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the block-length field width.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-005 Port start, input, 1: begin a new accumulation block; sampled in IDLE only.
REQ-006 Port block_len, input, LEN_W: number of results to accumulate; sampled with start.
REQ-007 Port abort, input, 1: synchronous cancel of any block in progress.
REQ-008 Port in_valid, input, 1: sum/carry_out present a valid adder result.
REQ-009 Port sum, input, N: low N bits of the upstream adder result.
REQ-010 Port carry_out, input, 1: bit N of the upstream adder result.
REQ-011 Port in_ready, output, 1: block accepts a result this cycle.
REQ-012 Port out_ready, input, 1: downstream accepts acc_total.
REQ-013 Port acc_valid, output, 1: acc_total holds a completed block total.
REQ-014 Port acc_total, output, N+1+LEN_W: running/final total of accepted results.
REQ-015 Port acc_count, output, LEN_W: number of results accepted in the current block.
REQ-016 Port busy, output, 1: block is not in IDLE.
REQ-017 Port len_err, output, 1: one-cycle pulse when start is issued with block_len=0.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-019 IDLE + start + block_len!=0 + !abort SHALL latch block_len, clear acc_total and acc_count, and go to ACCUM on the next edge.
REQ-020 IDLE + start + block_len=0 SHALL stay in IDLE and pulse len_err high for exactly one cycle.
REQ-021 start in ACCUM or HOLD SHALL be ignored; block_len changes after latching SHALL have no effect.
REQ-022 in_ready SHALL be 1 only in ACCUM (combinational from state); results offered in IDLE/HOLD SHALL be dropped, not stored.
REQ-023 On acceptance (in_valid & in_ready): acc_total SHALL add zero-extended {carry_out, sum}, and acc_count SHALL increment by 1.
REQ-024 acc_total SHALL NOT overflow, since its width N+1+LEN_W exceeds the maximum sum of (2^LEN_W-1) values of N+1 bits; no saturation logic SHALL be used.
REQ-025 The acceptance that brings acc_count to the latched length SHALL move the FSM to HOLD on the same edge, so that acc_valid=1 in the cycle after the last accept (latency 1).
REQ-026 In HOLD: acc_valid=1, and acc_total and acc_count SHALL be stable until out_ready=1; the handshake edge SHALL return the FSM to IDLE with acc_valid=0.
REQ-027 acc_valid SHALL be 0 in IDLE and ACCUM.
REQ-028 In IDLE, acc_total and acc_count SHALL retain the last block's values until the next valid start.
REQ-029 abort=1 in ACCUM or HOLD SHALL return to IDLE on the next edge, clear acc_total and acc_count, and produce no acc_valid; abort SHALL take priority over in_valid, out_ready and start.
REQ-030 abort=1 in IDLE with start=1 SHALL suppress the start, with no len_err pulse.
REQ-031 busy SHALL be 1 in ACCUM and HOLD, 0 in IDLE.
REQ-032 A latched block_len of 2^LEN_W-1 SHALL accumulate 255 results (default) without wrap of acc_count.

Reset
REQ-033 While rst=0: state=IDLE, acc_total=0, acc_count=0, acc_valid=0, in_ready=0, busy=0, len_err=0.
REQ-034 rst asserted mid-ACCUM or mid-HOLD SHALL discard the block immediately; after release the block SHALL wait in IDLE for start.
REQ-035 Release of rst SHALL be glitch-free in effect: the first start after release SHALL be honoured on the first rising edge.

Verification
REQ-036 len=3, results 0x0F/0, 0xFFFFFFFF/1, 0x00000001/0 -> acc_total=0x2_0000_000F (0x0F+0x1FFFFFFFF+0x1), acc_valid one cycle after third accept, acc_count=3.
REQ-037 HOLD with out_ready=0 for 5 cycles, then 1 -> acc_valid and acc_total stable for 6 cycles, IDLE next cycle, in_ready=0 throughout.
REQ-038 start with block_len=0 -> len_err high exactly 1 cycle, busy stays 0; start with len=2 in ACCUM -> ignored, block ends after 2 accepts.
REQ-039 len=4, abort after 2 accepts -> IDLE next edge, acc_total=0, acc_count=0, no acc_valid; same with abort during HOLD.
REQ-040 rst=0 pulsed between clock edges mid-ACCUM -> all outputs at reset values before the next edge.
REQ-041 255 random {carry_out, sum} pairs with len=255 and gapped in_valid -> acc_total equals the reference-model sum, and no result is accepted outside ACCUM.

Source files
------------

// File: rtl/adder_sum_accumulator_if.sv
// Stream interface for the adder-result accumulator: block control,
// upstream result handshake and downstream total handshake.
interface adder_sum_accumulator_if #(
    parameter int N     = 32,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] block_len;
    logic             abort;
    logic             in_valid;
    logic [N-1:0]     sum;
    logic             carry_out;
    logic             in_ready;
    logic             out_ready;
    logic             acc_valid;
    logic [N+LEN_W:0] acc_total;
    logic [LEN_W-1:0] acc_count;
    logic             busy;
    logic             len_err;

    modport master (
        output start, block_len, abort, in_valid, sum, carry_out, out_ready,
        input  in_ready, acc_valid, acc_total, acc_count, busy, len_err
    );

    modport slave (
        input  start, block_len, abort, in_valid, sum, carry_out, out_ready,
        output in_ready, acc_valid, acc_total, acc_count, busy, len_err
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates a block of {carry_out, sum} adder results and holds the
// total until the downstream consumer takes it.
module adder_sum_accumulator #(
    parameter int N     = 32,
    parameter int LEN_W = 8
) (
    input  logic clk,
    input  logic rst,
    adder_sum_accumulator_if.slave bus
);
    localparam int TOTAL_W = N + 1 + LEN_W;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   count_next;
    logic [TOTAL_W-1:0] total;
    logic               len_err_q;

    assign count_next = count + LEN_W'(1);

    // Abort wins over every other request; the total is wide enough that
    // a full block of maximum results cannot overflow it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            total     <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (bus.block_len == '0) begin
                            len_err_q <= 1'b1;
                        end else begin
                            len_q <= bus.block_len;
                            count <= '0;
                            total <= '0;
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.abort) begin
                        count <= '0;
                        total <= '0;
                        state <= IDLE;
                    end else if (bus.in_valid) begin
                        total <= total + TOTAL_W'({bus.carry_out, bus.sum});
                        count <= count_next;
                        if (count_next == len_q) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.abort) begin
                        count <= '0;
                        total <= '0;
                        state <= IDLE;
                    end else if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.acc_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_total = total;
    assign bus.acc_count = count;
    assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Randomized scoreboard bench for adder_sum_accumulator: a block-level
// model predicts totals, a monitor pops them on each output handshake.
module tb_adder_sum_accumulator;
    localparam int N     = 32;
    localparam int LEN_W = 8;

    typedef struct {
        longint unsigned total;
        int              count;
    } exp_t;

    logic clk;
    logic rst;

    adder_sum_accumulator_if #(.N(N), .LEN_W(LEN_W)) bus ();

    adder_sum_accumulator #(.N(N), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              num_checks = 0;
    int              num_errors = 0;
    exp_t            exp_q[$];
    bit              model_active = 0;
    bit              model_hold   = 0;
    int              model_len    = 0;
    int              model_cnt    = 0;
    longint unsigned model_total  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every output handshake must match the oldest predicted block.
    always @(negedge clk) begin
        if (rst && bus.acc_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected acc_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb acc_total", bus.acc_total, e.total);
                checkOutput("sb acc_count", bus.acc_count, 64'(e.count));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [N-1:0] s, input logic c);
        bus.in_valid  = v;
        bus.sum       = s;
        bus.carry_out = c;
        @(negedge clk);
        checkOutput("in_ready",  bus.in_ready,  64'(model_active));
        checkOutput("acc_valid", bus.acc_valid, 64'(model_hold));
        checkOutput("busy",      bus.busy,      64'(model_active || model_hold));
        checkOutput("acc_total", bus.acc_total, model_total);
        checkOutput("acc_count", bus.acc_count, 64'(model_cnt));
        checkOutput("len_err idle", bus.len_err, 64'd0);
        if (model_hold && bus.out_ready) begin
            model_hold = 0;
        end else if (model_active && v) begin
            model_total += 64'({c, s});
            model_cnt++;
            if (model_cnt == model_len) begin
                exp_q.push_back('{model_total, model_cnt});
                model_active = 0;
                model_hold   = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input int len, input logic ab);
        bus.start     = 1'b1;
        bus.abort     = ab;
        bus.block_len = LEN_W'(len);
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (len != 0 && !ab) begin
            model_active = 1;
            model_len    = len;
            model_total  = 0;
            model_cnt    = 0;
        end
        @(negedge clk);
        checkOutput("len_err after start", bus.len_err, 64'(len == 0 && !ab));
        checkOutput("busy after start", bus.busy, 64'(model_active));
        @(posedge clk);
        #1;
    endtask

    task automatic doAbort();
        logic saved;
        saved         = bus.out_ready;
        bus.out_ready = 1'b0;
        bus.abort     = 1'b1;
        bus.start     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.sum       = $urandom;
        @(negedge clk);
        checkOutput("in_ready at abort", bus.in_ready, 64'(model_active));
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = saved;
        if (model_hold) begin
            void'(exp_q.pop_back());
        end
        model_active = 0;
        model_hold   = 0;
        model_total  = 0;
        model_cnt    = 0;
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.block_len = '0;
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.carry_out = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        checkOutput("reset in_ready",  bus.in_ready,  64'd0);
        checkOutput("reset acc_valid", bus.acc_valid, 64'd0);
        checkOutput("reset busy",      bus.busy,      64'd0);
        checkOutput("reset acc_total", bus.acc_total, 64'd0);
        checkOutput("reset acc_count", bus.acc_count, 64'd0);
        checkOutput("reset len_err",   bus.len_err,   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Mixed-carry block with a known total
        doStart(3, 1'b0);
        applyStimulus(1'b1, 32'h0000_000F, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b1, 32'h0000_0001, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h1234_5678, 1'b1);
        checkOutput("fixed total retained", bus.acc_total, 64'h2_0000_000F);
        checkOutput("fixed count retained", bus.acc_count, 64'd3);

        // Downstream stall in HOLD with results offered and dropped
        bus.out_ready = 1'b0;
        doStart(2, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 1'b1);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);

        // Zero length, suppressed starts and a start issued mid-block
        doStart(0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        doStart(3, 1'b1);
        doStart(0, 1'b1);
        doStart(2, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b0);
        bus.start     = 1'b1;
        bus.block_len = 8'd5;
        applyStimulus(1'b1, $urandom, 1'b1);
        bus.start = 1'b0;
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Abort mid-ACCUM and in HOLD
        doStart(4, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b1, $urandom, 1'b0);
        doAbort();
        bus.out_ready = 1'b0;
        doStart(2, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        doAbort();
        bus.out_ready = 1'b1;

        // Asynchronous reset between edges, then an immediate start
        doStart(4, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b1, $urandom, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async in_ready",  bus.in_ready,  64'd0);
        checkOutput("async busy",      bus.busy,      64'd0);
        checkOutput("async acc_total", bus.acc_total, 64'd0);
        checkOutput("async acc_count", bus.acc_count, 64'd0);
        checkOutput("async acc_valid", bus.acc_valid, 64'd0);
        model_active = 0;
        model_hold   = 0;
        model_total  = 0;
        model_cnt    = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        doStart(1, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Full-length random block with gapped valids
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)));
        doStart(255, 1'b0);
        for (int i = 0; i < 3000 && model_active; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
        end
        checkOutput("random block completed", 64'(model_active), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)));

        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
        $finish;
    end
endmodule
